// File: rtl/requant_rr_sched_pkg.sv
// Shared fixed-point formats and saturation helpers for the requantizer scheduler.
package requant_rr_sched_pkg;

    // FX_WIDE (17,10) input format and FX_NARROW (9,7) output format
    localparam int FX_WIDE_NB    = 17;
    localparam int FX_WIDE_NBF   = 10;
    localparam int FX_NARROW_NB  = 9;
    localparam int FX_NARROW_NBF = 7;

    localparam int K       = FX_WIDE_NBF - FX_NARROW_NBF;
    localparam int MAX_RAW = (2 ** (FX_NARROW_NB - 1)) - 1;
    localparam int MIN_RAW = -(2 ** (FX_NARROW_NB - 1));

    localparam int DEF_N_CH  = 4;
    localparam int DEF_CNT_W = 16;

    // Saturation event for one FX_WIDE word: the shifted value is out of
    // range, or sits at the top code and rounding would push it over.
    function automatic logic sat_hit(input logic [FX_WIDE_NB-1:0] x);
        logic signed [FX_WIDE_NB-K-1:0] y;
        logic                           inc;
        y   = x[FX_WIDE_NB-1:K];
        inc = x[K-1] & ((|x[K-2:0]) | y[0]);
        return (int'(y) > MAX_RAW) || (int'(y) < MIN_RAW) ||
               ((int'(y) == MAX_RAW) && inc);
    endfunction

endpackage

// File: rtl/requant_rr_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// and moves the pointer just past the winner whenever a grant issues.
module rr_arbiter
    import requant_rr_sched_pkg::*;
#(
    parameter int N_CH = DEF_N_CH,
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [N_CH-1:0] req,
    output logic [N_CH-1:0] grant,
    output logic [CH_W-1:0] grant_idx
);

    localparam int unsigned NU = N_CH;

    logic [CH_W-1:0] ptr;
    logic [CH_W-1:0] cand;
    logic            found;

    // Cyclic priority search starting at the pointer
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int unsigned i = 0; i < NU; i++) begin
            cand = CH_W'((32'(ptr) + i) % NU);
            if (!found && req[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
        if (en && found) begin
            grant[grant_idx] = 1'b1;
        end
    end

    // Pointer advances only when a grant actually issues
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (|grant) begin
            ptr <= (grant_idx == CH_W'(N_CH - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/requant_rr_sched_sat_trunc.sv
// Signed requantizer: drop fractional bits with round-half-even, then
// saturate to the narrow word. Also flags a saturation event.
module sat_trunc
    import requant_rr_sched_pkg::*;
#(
    parameter int NB_XI  = FX_WIDE_NB,
    parameter int NBF_XI = FX_WIDE_NBF,
    parameter int NB_XO  = FX_NARROW_NB,
    parameter int NBF_XO = FX_NARROW_NBF,
    parameter bit ROUND  = 1'b1
) (
    input  logic [NB_XI-1:0] x,
    output logic [NB_XO-1:0] y,
    output logic             sat
);

    localparam int SHIFT = NBF_XI - NBF_XO;
    // one spare bit so the rounding increment can never overflow
    localparam int NB_R  = NB_XI - SHIFT + 1;

    localparam logic signed [NB_R-1:0] HI = NB_R'((1 << (NB_XO - 1)) - 1);
    localparam logic signed [NB_R-1:0] LO = NB_R'(-(1 << (NB_XO - 1)));
    localparam logic [NB_XO-1:0] Y_HI = {1'b0, {(NB_XO-1){1'b1}}};
    localparam logic [NB_XO-1:0] Y_LO = {1'b1, {(NB_XO-1){1'b0}}};

    logic signed [NB_R-1:0] base;
    logic signed [NB_R-1:0] rnd;
    logic                   inc;

    if (SHIFT == 0) begin : g_noshift
        assign base = {x[NB_XI-1], x};
        assign inc  = 1'b0;
    end else begin : g_shift
        assign base = {x[NB_XI-1], x[NB_XI-1:SHIFT]};
        if (!ROUND) begin : g_trunc
            assign inc = 1'b0;
        end else if (SHIFT == 1) begin : g_rne1
            assign inc = x[0] & x[1];
        end else begin : g_rne
            // round up above half, or exactly half when the kept LSB is odd
            assign inc = x[SHIFT-1] & ((|x[SHIFT-2:0]) | x[SHIFT]);
        end
    end

    assign rnd = base + $signed({{(NB_R-1){1'b0}}, inc});

    // Clamp the rounded value and flag out-of-range inputs
    always_comb begin
        sat = (base > HI) | (base < LO) | ((base == HI) & inc);
        if (rnd > HI) begin
            y = Y_HI;
        end else if (rnd < LO) begin
            y = Y_LO;
        end else begin
            y = rnd[NB_XO-1:0];
        end
    end

endmodule

// File: rtl/requant_rr_sched.sv
// Shares one requantizer between N_CH requesters with round-robin grants,
// a single output register and per-channel saturation counters.
module requant_rr_sched
    import requant_rr_sched_pkg::*;
#(
    parameter int N_CH   = DEF_N_CH,
    parameter int NB_XI  = FX_WIDE_NB,
    parameter int NBF_XI = FX_WIDE_NBF,
    parameter int NB_XO  = FX_NARROW_NB,
    parameter int NBF_XO = FX_NARROW_NBF,
    parameter int CNT_W  = DEF_CNT_W,
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic [N_CH-1:0]       i_valid,
    input  logic [N_CH*NB_XI-1:0] i_data,
    output logic [N_CH-1:0]       o_ready,
    output logic                  o_valid,
    output logic [NB_XO-1:0]      o_data,
    output logic [CH_W-1:0]       o_ch,
    input  logic                  i_ready,
    input  logic                  i_clr_cnt,
    output logic [N_CH*CNT_W-1:0] o_sat_cnt
);

    logic                             slot_free;
    logic                             transfer;
    logic [CH_W-1:0]                  sel;
    logic [NB_XI-1:0]                 word;
    logic [NB_XO-1:0]                 q;
    logic                             hit;
    logic [N_CH-1:0][CNT_W-1:0]       cnt;

    // reset also gates grants so nothing is offered while held in reset
    assign slot_free = !o_valid | i_ready;
    assign transfer  = |o_ready;
    assign word      = i_data[sel*NB_XI +: NB_XI];
    assign o_sat_cnt = cnt;

    rr_arbiter #(
        .N_CH (N_CH)
    ) u_arb (
        .clk       (i_clk),
        .rst       (i_rst),
        .en        (i_en & slot_free & !i_rst),
        .req       (i_valid),
        .grant     (o_ready),
        .grant_idx (sel)
    );

    sat_trunc #(
        .NB_XI  (NB_XI),
        .NBF_XI (NBF_XI),
        .NB_XO  (NB_XO),
        .NBF_XO (NBF_XO),
        .ROUND  (1'b1)
    ) u_sat (
        .x   (word),
        .y   (q),
        .sat (hit)
    );

    // Output slot: load on accept, drop valid on consume, hold otherwise
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_ch    <= '0;
        end else if (transfer) begin
            o_valid <= 1'b1;
            o_data  <= q;
            o_ch    <= sel;
        end else if (i_ready) begin
            o_valid <= 1'b0;
        end
    end

    // Saturation-event counters: sticky at all-ones, clear has priority
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt <= '0;
        end else if (i_clr_cnt) begin
            cnt <= '0;
        end else begin
            for (int unsigned c = 0; c < N_CH; c++) begin
                if (transfer && (sel == CH_W'(c)) && hit && (cnt[c] != '1)) begin
                    cnt[c] <= cnt[c] + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_requant_rr_sched.sv
// Directed and random checks of the round-robin requantizer scheduler
// against an independent arbiter/rounding model and an output scoreboard.
module tb_requant_rr_sched;

    localparam int NCH = 4;
    localparam int NBI = 17;
    localparam int NBO = 9;
    localparam int CW  = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 en;
    logic                 ready;
    logic                 clr;
    logic [NCH-1:0]       valid;
    logic [NCH*NBI-1:0]   data;
    logic [NCH-1:0]       o_ready;
    logic                 o_valid;
    logic [NBO-1:0]       o_data;
    logic [1:0]           o_ch;
    logic [NCH*CW-1:0]    sat_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [8:0] d;
        logic [1:0] ch;
    } exp_t;

    exp_t sb[$];
    int   m_ptr;
    bit   m_valid;
    int   m_cnt[NCH];
    int   n_acc = 0;

    int t4_in[4]  = '{2044, -2056, -2048, 2040};
    int t4_exp[4] = '{32'h0FF, 32'h100, 32'h100, 32'h0FF};

    requant_rr_sched #(
        .N_CH  (NCH),
        .CNT_W (CW)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_en      (en),
        .i_valid   (valid),
        .i_data    (data),
        .o_ready   (o_ready),
        .o_valid   (o_valid),
        .o_data    (o_data),
        .o_ch      (o_ch),
        .i_ready   (ready),
        .i_clr_cnt (clr),
        .o_sat_cnt (sat_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int c, input int v);
        data[c*NBI +: NBI] = v[NBI-1:0];
    endtask

    // Golden requantizer in real arithmetic: round half to even, clamp to 9 bits
    function automatic void golden(input int x, output int q, output bit hit);
        real v, r, f;
        v = x / 8.0;
        r = $floor(v);
        f = v - r;
        if (f > 0.5 || (f == 0.5 && (($rtoi(r) % 2) != 0))) r = r + 1.0;
        q   = $rtoi(r);
        hit = (v < -256.0) || (q > 255);
        if (q > 255)  q = 255;
        if (q < -256) q = -256;
    endfunction

    // Reference model evaluated mid-cycle; its updates describe the next rising edge
    always @(negedge clk) begin
        if (rst) begin
            m_ptr   = 0;
            m_valid = 0;
            foreach (m_cnt[c]) m_cnt[c] = 0;
            sb.delete();
        end else begin
            logic [NCH-1:0]       eg;
            bit                   found;
            int                   g, q, x, cc;
            bit                   hit;
            logic signed [NBI-1:0] raw;
            exp_t                 e;
            eg = '0;
            found = 0;
            g = 0;
            if (en && (!m_valid || ready)) begin
                for (int k = 0; k < NCH; k++) begin
                    cc = (m_ptr + k) % NCH;
                    if (!found && valid[cc]) begin
                        found = 1;
                        g = cc;
                    end
                end
                if (found) eg[g] = 1'b1;
            end
            chk("o_ready", 32'(o_ready), 32'(eg));
            chk("o_valid", 32'(o_valid), 32'(m_valid));
            for (int c = 0; c < NCH; c++) chk("sat_cnt", 32'(sat_cnt[c*CW +: CW]), m_cnt[c]);
            if (m_valid && ready) begin
                chk("sb_nonempty", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("o_data", 32'(o_data), 32'(e.d));
                    chk("o_ch", 32'(o_ch), 32'(e.ch));
                end
                m_valid = 0;
            end
            if (found) begin
                raw = data[g*NBI +: NBI];
                x = int'(raw);
                golden(x, q, hit);
                e.d  = q[8:0];
                e.ch = g[1:0];
                sb.push_back(e);
                m_valid = 1;
                m_ptr = (g + 1) % NCH;
                n_acc++;
                if (hit && m_cnt[g] < 15) m_cnt[g]++;
            end
            if (clr) foreach (m_cnt[c]) m_cnt[c] = 0;
        end
    end

    initial begin
        int start;
        int x;
        rst = 1; en = 1; ready = 1; clr = 0; valid = '1; data = '0;
        #2;
        chk("rst_o_ready", 32'(o_ready), 0);
        chk("rst_o_valid", 32'(o_valid), 0);
        chk("rst_o_data", 32'(o_data), 0);
        chk("rst_o_ch", 32'(o_ch), 0);
        chk("rst_sat_cnt", 32'(sat_cnt), 0);
        tick();
        tick();
        valid = '0;
        rst = 0;

        // single channel, rounding 12/8 = 1.5 -> 2
        set_ch(0, 12);
        valid = 4'b0001;
        #1;
        chk("t1_ready", 32'(o_ready), 32'h1);
        tick();
        valid = '0;
        chk("t1_valid", 32'(o_valid), 1);
        chk("t1_data", 32'(o_data), 2);
        chk("t1_ch", 32'(o_ch), 0);
        chk("t1_cnt0", 32'(sat_cnt[0 +: CW]), 0);
        tick();
        chk("t1_drain", 32'(o_valid), 0);

        // all channels requesting, pointer starts at 1
        for (int c = 0; c < NCH; c++) set_ch(c, c * 8);
        valid = '1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("t2_valid", 32'(o_valid), 1);
            chk("t2_ch", 32'(o_ch), k % 4);
            chk("t2_data", 32'(o_data), k % 4);
        end

        // backpressure hold
        ready = 0;
        #1;
        chk("t3_ready0", 32'(o_ready), 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t3_hold_ready", 32'(o_ready), 0);
            chk("t3_hold_valid", 32'(o_valid), 1);
            chk("t3_hold_ch", 32'(o_ch), 0);
            chk("t3_hold_data", 32'(o_data), 0);
        end
        ready = 1;
        #1;
        chk("t3_release_ready", 32'(o_ready), 32'h2);
        tick();
        chk("t3_next_ch", 32'(o_ch), 1);
        valid = '0;
        tick();
        chk("t3_drain", 32'(o_valid), 0);

        // rounding/saturation boundaries on ch2
        valid = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            set_ch(2, t4_in[i]);
            tick();
            chk("t4_ch", 32'(o_ch), 2);
            chk("t4_data", 32'(o_data), t4_exp[i]);
        end
        valid = '0;
        chk("t4_cnt2", 32'(sat_cnt[2*CW +: CW]), 2);
        tick();

        // counter saturation and clear priority
        set_ch(1, 4000);
        valid = 4'b0010;
        repeat (20) tick();
        chk("t5_cnt1_sat", 32'(sat_cnt[1*CW +: CW]), 15);
        clr = 1;
        tick();
        clr = 0;
        chk("t5_clr", 32'(sat_cnt), 0);
        valid = '0;
        tick();

        // reset while ch3 output is pending
        set_ch(3, 4000);
        valid = 4'b1000;
        tick();
        chk("t6_ch", 32'(o_ch), 3);
        chk("t6_cnt3", 32'(sat_cnt[3*CW +: CW]), 1);
        ready = 0;
        valid = '1;
        tick();
        chk("t6_pending", 32'(o_valid), 1);
        rst = 1;
        #1;
        chk("t6_rst_valid", 32'(o_valid), 0);
        chk("t6_rst_cnt", 32'(sat_cnt), 0);
        chk("t6_rst_ready", 32'(o_ready), 0);
        chk("t6_rst_data", 32'(o_data), 0);
        tick();
        rst = 0;
        ready = 1;
        #1;
        chk("t6_first_grant", 32'(o_ready), 32'h1);
        tick();
        chk("t6_first_ch", 32'(o_ch), 0);

        // random traffic against the scoreboard
        start = n_acc;
        for (int cyc = 0; cyc < 20000 && (n_acc - start) < 1000; cyc++) begin
            valid = NCH'($urandom);
            en    = ($urandom_range(0, 7) != 0);
            ready = ($urandom_range(0, 3) != 0);
            clr   = ($urandom_range(0, 63) == 0);
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 1) != 0) x = int'($urandom_range(0, 4400)) - 2200;
                else x = int'($urandom_range(0, 131071)) - 65536;
                set_ch(c, x);
            end
            tick();
        end
        chk("rand_count", 32'((n_acc - start) >= 1000), 1);
        valid = '0; ready = 1; en = 1; clr = 0;
        tick();
        tick();
        chk("final_valid", 32'(o_valid), 0);
        chk("final_sb_empty", 32'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
